load_store_unit: RTL
====================

# load_store_unit

Parametrised data-memory load/store unit for the single-issue RISC-V core, sitting beside the ALU in the execute stage. It replaces the fixed-size data-memory path. It adds the following over the previous unit:
- configurable RAM depth and base addresses;
- a bank of byte-wide memory-mapped I/O output registers and readable input bytes;
- a write path for aligned `SW` that skips the read;
- range checking;
- an explicit state machine with asynchronous reset.

## Interface
Parameters:
- `DATA_PATH`, `""`: hex initialisation file for the data RAM.
- `ADDRESS_BITS`, `10`: RAM word-address width. RAM size is 4·2^ADDRESS_BITS bytes.
- `DATA_BASE`, `32'h0000_1000`: byte address of RAM word 0.
- `MMIO_BASE`, `32'h0000_2000`: byte address of I/O byte 0.
- `MMIO_COUNT`, `4`: number of I/O bytes, between 1 and 16.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `subfunction_3` input 3: funct3 of the memory instruction.
- `input_register1_value` input 32: rs1, the base address.
- `input_register2_value` input 32: rs2, the store data.
- `immediate` input 32: sign-extended offset.
- `opcode_is_load` input 1: a load is presented this cycle.
- `opcode_is_store` input 1: a store is presented this cycle.
- `clk_stall` output 1: combinational; freezes the core while high.
- `load_error` output 1: combinational load fault.
- `store_error` output 1: combinational store fault.
- `result_to_write_rd` output 32: registered load result.
- `mmio_out` output 8·MMIO_COUNT: I/O output registers; byte k is `[8k+7:8k]`.
- `mmio_in` input 8·MMIO_COUNT: I/O input bytes, sampled on load.

## Operation
- Effective address is `ea = rs1 + imm`, modulo 2^32.
- RAM hit: `DATA_BASE ≤ ea < DATA_BASE + 4·2^ADDRESS_BITS`. The word index is `(ea − DATA_BASE)[ADDRESS_BITS+1:2]`.
- MMIO hit: `MMIO_BASE ≤ ea < MMIO_BASE + MMIO_COUNT`. The byte index is `ea − MMIO_BASE`.
- Fault conditions:
  - funct3 is not a legal load (LB/LH/LW/LBU/LHU) or store (SB/SH/SW);
  - misaligned access: a halfword needs `ea[0]=0`, a word needs `ea[1:0]=0`;
  - address is in neither range;
  - MMIO access other than SB/LB/LBU;
  - `opcode_is_load` and `opcode_is_store` both high, which raises both errors.
- `load_error` is valid only with `opcode_is_load`; `store_error` only with `opcode_is_store`. A faulting access has no side effect, leaves the state machine in IDLE and keeps `clk_stall` at 0.
- State machine states: IDLE, READ, DONE.
  - IDLE, RAM load → issue RAM read, go to READ.
  - IDLE, SB/SH to RAM → issue RAM read, go to READ.
  - IDLE, SW to RAM → write rs2 directly, go to DONE.
  - IDLE, MMIO store → update `mmio_out` byte at the edge, stay in IDLE, no stall.
  - IDLE, MMIO load → register the extended `mmio_in` byte, go to DONE.
  - READ, load → register the extracted, sign- or zero-extended result, go to DONE.
  - READ, SB/SH → write the merged word (rs2 bytes replace the addressed lanes, other lanes come from the read data), go to DONE.
  - DONE → go to IDLE.
- `clk_stall = (opcode_is_load | opcode_is_store) & no fault & state≠DONE & !(MMIO store)`.
- Byte lane is `ea[1:0]`, little-endian. A halfword uses lanes `{1,0}` or `{3,2}`.
- The core holds all inputs stable while `clk_stall` is high. `result_to_write_rd` holds its value until the next load completes.

## Timing
- Reset values: state IDLE, `clk_stall` 0, `result_to_write_rd` 0, `mmio_out` all 0. RAM contents are not reset.
- RAM read latency is one cycle: data is valid in the cycle after the read enable.
- Cycles per instruction, including the final non-stalled cycle:
  - RAM load: 3;
  - SB/SH to RAM: 3;
  - SW to RAM: 2;
  - MMIO load: 2;
  - MMIO store: 1;
  - faulting access: 1.
- Back-to-back accesses: DONE always returns to IDLE, so the next instruction starts one cycle later with no extra bubble.
- Reset asserted in READ: no RAM write occurs, the state returns to IDLE immediately and `clk_stall` drops asynchronously.
- Address wrap at 2^32 is not special: an address that wraps outside both ranges faults.

## Test plan
- Reset, then release → `clk_stall`=0, `result_to_write_rd`=0, `mmio_out`=0.
- SW `0xDEADBEEF` at `0x1004`, then LW `0x1004` → stall high for 1 cycle then 2 cycles; result `0xDEADBEEF`.
- Starting from that word: SB `0x80` at `0x1006` (stall 2 cycles) → LB `0x1006`=`0xFFFFFF80`, LBU=`0x00000080`, LW `0x1004`=`0xDE80BEEF`.
- SH at `0x1001`, LW at `0x1002`, LW at `0x0FFC`, and funct3=3 store → each raises its error with `clk_stall`=0; a following LW `0x1004` still reads `0xDE80BEEF`.
- SB `0x5A` to `MMIO_BASE+2` → `mmio_out[23:16]`=`0x5A` with no stall. With `mmio_in[15:8]`=`0xF0`: LB `MMIO_BASE+1` → `0xFFFFFFF0`, LBU → `0x000000F0`. SW to `MMIO_BASE` → `store_error`.
- SB `0x11` at `0x1004`, with `reset` pulsed during READ → `clk_stall` drops at once; after release, LW `0x1004` = `0xDE80BEEF`.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V data-memory load/store unit with RAM, byte-wide MMIO and range checking
module load_store_unit #(
  parameter string       DATA_PATH    = "",
  parameter int          ADDRESS_BITS = 10,
  parameter logic [31:0] DATA_BASE    = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE    = 32'h0000_2000,
  parameter int          MMIO_COUNT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              subfunction_3,
  input  logic [31:0]             input_register1_value,
  input  logic [31:0]             input_register2_value,
  input  logic [31:0]             immediate,
  input  logic                    opcode_is_load,
  input  logic                    opcode_is_store,
  output logic                    clk_stall,
  output logic                    load_error,
  output logic                    store_error,
  output logic [31:0]             result_to_write_rd,
  output logic [8*MMIO_COUNT-1:0] mmio_out,
  input  logic [8*MMIO_COUNT-1:0] mmio_in
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Range bounds are kept 33 bits wide so a range ending at 2^32 cannot wrap.
  localparam logic [32:0] RAM_LO  = {1'b0, DATA_BASE};
  localparam logic [32:0] RAM_HI  = RAM_LO + (33'd4 << ADDRESS_BITS);
  localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [32:0] MMIO_HI = MMIO_LO + 33'(MMIO_COUNT);

  logic [1:0]              state;
  logic [31:0]             ram [0:(1<<ADDRESS_BITS)-1];
  logic [31:0]             rdata;
  logic [31:0]             ea;
  logic [31:0]             mmio_off;
  logic [ADDRESS_BITS-1:0] ram_index;
  logic [1:0]              size;
  logic                    ram_hit, mmio_hit, misaligned, common_bad, both;
  logic                    load_f3_ok, store_f3_ok, valid, mmio_store;
  logic                    ram_re, ram_we;
  logic [7:0]              sel_byte, mmio_byte;
  logic [15:0]             sel_half;
  logic [31:0]             load_data, merged;

  assign ea        = input_register1_value + immediate;
  assign mmio_off  = ea - MMIO_BASE;
  assign ram_index = ADDRESS_BITS'((ea - DATA_BASE) >> 2);
  assign size      = subfunction_3[1:0];
  assign ram_hit   = ({1'b0, ea} >= RAM_LO) && ({1'b0, ea} < RAM_HI);
  assign mmio_hit  = !ram_hit && ({1'b0, ea} >= MMIO_LO) && ({1'b0, ea} < MMIO_HI);

  always_comb begin
    both        = opcode_is_load & opcode_is_store;
    misaligned  = (size == 2'd1 && ea[0]) || (size == 2'd2 && ea[1:0] != 2'b00);
    load_f3_ok  = subfunction_3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    store_f3_ok = subfunction_3 inside {3'd0, 3'd1, 3'd2};
    // MMIO is byte-only, so any non-byte width there is a fault.
    common_bad  = misaligned || !(ram_hit || mmio_hit) || (mmio_hit && size != 2'd0);
    load_error  = opcode_is_load  & (both | !load_f3_ok  | common_bad);
    store_error = opcode_is_store & (both | !store_f3_ok | common_bad);
    valid       = (opcode_is_load | opcode_is_store) & !load_error & !store_error;
    mmio_store  = valid & opcode_is_store & mmio_hit;
    clk_stall   = valid & (state != DONE) & !mmio_store & !reset;
  end

  always_comb begin
    mmio_byte = 8'h00;
    for (int k = 0; k < MMIO_COUNT; k++)
      if (mmio_off == 32'(k)) mmio_byte = mmio_in[8*k +: 8];
    case (ea[1:0])
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    if (mmio_hit) sel_byte = mmio_byte;
    sel_half = ea[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    load_data = subfunction_3[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'd1:    load_data = subfunction_3[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged = rdata;
    case (size)
      2'd0:    merged[{ea[1:0], 3'b000} +: 8] = input_register2_value[7:0];
      2'd1:    merged[{ea[1], 4'b0000} +: 16] = input_register2_value[15:0];
      default: merged = input_register2_value;
    endcase
  end

  // Aligned SW writes straight from IDLE; SB/SH read first and write the merged word from READ.
  assign ram_re = (state == IDLE) & valid & ram_hit & !(opcode_is_store & size == 2'd2);
  assign ram_we = valid & ram_hit & opcode_is_store &
                  (((state == IDLE) & size == 2'd2) | (state == READ));

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_index] <= merged;
    if (ram_re) rdata <= ram[ram_index];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      result_to_write_rd <= 32'h0;
      mmio_out           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            if (ram_hit) begin
              state <= (opcode_is_store && size == 2'd2) ? DONE : READ;
            end else if (opcode_is_load) begin
              result_to_write_rd <= load_data;
              state              <= DONE;
            end else begin
              for (int k = 0; k < MMIO_COUNT; k++)
                if (mmio_off == 32'(k)) mmio_out[8*k +: 8] <= input_register2_value[7:0];
            end
          end
        end
        READ: begin
          if (opcode_is_load) result_to_write_rd <= load_data;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
